// File: rtl/move_sequencer_if.sv
// Move-check handshake between the move sequencer and the collision-check datapath.
//   chk_req : sequencer -> datapath, move request held until acknowledged
//   chk_op  : sequencer -> datapath, 0 DOWN, 1 LEFT, 2 RIGHT, 3 ROT
//   chk_ack : datapath -> sequencer, one-cycle response strobe
//   chk_ok  : datapath -> sequencer, move legal (valid with chk_ack)
//   commit  : sequencer -> datapath, one-cycle pulse to apply the accepted move
interface move_sequencer_if;
    logic       chk_req;
    logic [2:0] chk_op;
    logic       chk_ack;
    logic       chk_ok;
    logic       commit;

    modport master (
        output chk_req,
        output chk_op,
        output commit,
        input  chk_ack,
        input  chk_ok
    );

    modport slave (
        input  chk_req,
        input  chk_op,
        input  commit,
        output chk_ack,
        output chk_ok
    );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: collects user commands and gravity ticks as pending flags,
// arbitrates them one at a time into move-check requests and turns the datapath
// answer into commit / placed pulses.
//   clka        : sole clock, rising edge
//   restart_n   : asynchronous active-low reset
//   active      : game FSM is in MOVE; the sequencer runs only while high
//   btn_left, btn_right, btn_rot, btn_drop : single-cycle command pulses
//   chk         : move-check handshake (master side), see move_sequencer_if
//   placed      : one-cycle pulse when the piece has landed
//   busy        : high whenever the sequencer is not idle
// Build option: define MOVE_SEQUENCER_HARD_DROP_EN to enable hard drop; otherwise
// btn_drop is ignored.
module move_sequencer #(
    parameter int unsigned GRAVITY_PERIOD = 1000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic             clka,
    input  logic             restart_n,
    input  logic             active,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_rot,
    input  logic             btn_drop,
    move_sequencer_if.master chk,
    output logic             placed,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StArb, StReq, StPlace} state_e;

    localparam logic [2:0] OpDown  = 3'd0;
    localparam logic [2:0] OpLeft  = 3'd1;
    localparam logic [2:0] OpRight = 3'd2;
    localparam logic [2:0] OpRot   = 3'd3;

    // Pending-flag bit positions
    localparam int PDrop  = 4;
    localparam int PGrav  = 3;
    localparam int PRot   = 2;
    localparam int PLeft  = 1;
    localparam int PRight = 0;

    localparam logic [CNT_W-1:0] GravMax = CNT_W'(GRAVITY_PERIOD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
    logic [4:0]       pend_q, pend_d, pend_set;
    logic             drop_run_q, drop_run_d;
    logic [2:0]       op_q, op_d;
    logic             commit_q, commit_d;
    logic             placed_q, placed_d;
    logic             ready_q;
    logic             grav_tick;
    logic             drop_set;

`ifdef MOVE_SEQUENCER_HARD_DROP_EN
    assign drop_set = btn_drop;
`else
    logic unused_btn_drop;
    assign unused_btn_drop = btn_drop;
    assign drop_set        = 1'b0;
`endif

    assign pend_set = {drop_set, grav_tick, btn_rot, btn_left, btn_right};

    always_comb begin
        state_d    = state_q;
        grav_cnt_d = grav_cnt_q;
        pend_d     = pend_q;
        drop_run_d = drop_run_q;
        op_d       = op_q;
        commit_d   = 1'b0;
        placed_d   = 1'b0;
        grav_tick  = 1'b0;

        if (!active) begin
            // Leaving MOVE abandons everything, including an outstanding request.
            state_d    = StIdle;
            grav_cnt_d = '0;
            pend_d     = '0;
            drop_run_d = 1'b0;
        end else begin
            if (state_q != StPlace) begin
                if (grav_cnt_q == GravMax) begin
                    grav_cnt_d = '0;
                    grav_tick  = 1'b1;
                end else begin
                    grav_cnt_d = grav_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    // ready_q holds off the first ARB until the second edge after reset
                    if (ready_q) state_d = StArb;
                end
                StArb: begin
                    state_d = StReq;
                    if (drop_run_q) begin
                        // Hard drop in progress: keep issuing DOWN, other flags wait.
                        op_d = OpDown;
                    end else if (pend_q[PDrop]) begin
                        pend_d[PDrop] = 1'b0;
                        drop_run_d    = 1'b1;
                        op_d          = OpDown;
                    end else if (pend_q[PGrav]) begin
                        pend_d[PGrav] = 1'b0;
                        op_d          = OpDown;
                    end else if (pend_q[PRot]) begin
                        pend_d[PRot] = 1'b0;
                        op_d         = OpRot;
                    end else if (pend_q[PLeft]) begin
                        pend_d[PLeft] = 1'b0;
                        op_d          = OpLeft;
                    end else if (pend_q[PRight]) begin
                        pend_d[PRight] = 1'b0;
                        op_d           = OpRight;
                    end else begin
                        state_d = StArb;
                    end
                end
                StReq: begin
                    if (chk.chk_ack) begin
                        if (chk.chk_ok) begin
                            commit_d = 1'b1;
                            state_d  = StArb;
                        end else if (op_q == OpDown) begin
                            placed_d   = 1'b1;
                            state_d    = StPlace;
                            drop_run_d = 1'b0;
                            pend_d     = '0;
                        end else begin
                            state_d = StArb;
                        end
                    end
                end
                StPlace: begin
                    // Wait for active to fall; handled above.
                end
                default: state_d = StIdle;
            endcase

            // New pulses are merged after consumption so a same-cycle set survives;
            // nothing is recorded once the piece is landing or landed.
            if (state_d != StPlace) pend_d = pend_d | pend_set;
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q    <= StIdle;
            grav_cnt_q <= '0;
            pend_q     <= '0;
            drop_run_q <= 1'b0;
            op_q       <= OpDown;
            commit_q   <= 1'b0;
            placed_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grav_cnt_q <= grav_cnt_d;
            pend_q     <= pend_d;
            drop_run_q <= drop_run_d;
            op_q       <= op_d;
            commit_q   <= commit_d;
            placed_q   <= placed_d;
            ready_q    <= 1'b1;
        end
    end

    assign chk.chk_req = (state_q == StReq);
    assign chk.chk_op  = op_q;
    assign chk.commit  = commit_q;
    assign placed      = placed_q;
    assign busy        = (state_q != StIdle);

endmodule
